// File: rtl/serial_frame_receiver_pkg.sv
// Shared definitions for the serial frame receiver: FSM state encoding and line-level constants.
package serial_frame_receiver_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic IDLE_LINE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/serial_frame_receiver_rx_shift_core.sv
// Shift/accumulate datapath: collects serial data bits LSB-first (right shift) or MSB-first (left shift).
module rx_shift_core #(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_q <= '0;
    end else if (shift_en) begin
      if (MSB_FIRST) begin
        r_q <= {r_q[WIDTH-2:0], bit_in};
      end else begin
        r_q <= {bit_in, r_q[WIDTH-1:1]};
      end
    end
  end

  assign q = r_q;

endmodule

// File: rtl/serial_frame_receiver.sv
// Serial frame receiver: start bit, WIDTH data bits, even parity, stop bit, with a valid/ready output stage.
module serial_frame_receiver
  import serial_frame_receiver_pkg::*;
#(
  parameter int unsigned WIDTH     = 4,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bit_en,
  input  logic             serial_in,
  output logic [WIDTH-1:0] Out,
  output logic             valid,
  input  logic             ready,
  output logic             parity_err,
  output logic             frame_err,
  output logic             overrun,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  rx_state_t        r_state;
  rx_state_t        w_state_next;
  logic [CW-1:0]    r_cnt;
  logic             r_par_bit;
  logic [WIDTH-1:0] r_out;
  logic             r_valid;
  logic             r_parity_err;
  logic             r_frame_err;
  logic             r_overrun;

  logic             w_clear;
  logic             w_shift;
  logic             w_cap_par;
  logic             w_stop_sample;
  logic             w_good_stop;
  logic             w_load;
  logic             w_par_fail;
  logic [WIDTH-1:0] w_q;

  rx_shift_core #(
    .WIDTH    (WIDTH),
    .MSB_FIRST(MSB_FIRST)
  ) u_shift (
    .clk     (clk),
    .rst     (rst),
    .clear   (w_clear),
    .shift_en(w_shift),
    .bit_in  (serial_in),
    .q       (w_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_clear       = 1'b0;
    w_shift       = 1'b0;
    w_cap_par     = 1'b0;
    w_stop_sample = 1'b0;
    if (bit_en) begin
      case (r_state)
        IDLE: begin
          if (serial_in == START_BIT) begin
            w_clear      = 1'b1;
            w_state_next = DATA;
          end
        end
        DATA: begin
          w_shift = 1'b1;
          if (r_cnt == LAST_IDX) begin
            w_state_next = PARITY;
          end
        end
        PARITY: begin
          w_cap_par    = 1'b1;
          w_state_next = STOP;
        end
        STOP: begin
          w_stop_sample = 1'b1;
          w_state_next  = IDLE;
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_cnt <= '0;
    end else if (w_shift) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_par_bit <= 1'b0;
    end else if (w_cap_par) begin
      r_par_bit <= serial_in;
    end
  end

  assign w_par_fail  = (^w_q) ^ r_par_bit;
  assign w_good_stop = w_stop_sample && (serial_in == STOP_BIT);
  // A consumer taking the old word on the same edge frees the slot for the new one.
  assign w_load      = w_good_stop && (!r_valid || ready);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_out        <= '0;
      r_valid      <= 1'b0;
      r_parity_err <= 1'b0;
      r_frame_err  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      if (w_load) begin
        r_out        <= w_q;
        r_parity_err <= w_par_fail;
        r_valid      <= 1'b1;
      end else if (r_valid && ready) begin
        r_valid <= 1'b0;
      end
      if (w_good_stop && r_valid && !ready) begin
        r_overrun <= 1'b1;
      end
      if (w_stop_sample && (serial_in != STOP_BIT)) begin
        r_frame_err <= 1'b1;
      end
    end
  end

  assign Out        = r_out;
  assign valid      = r_valid;
  assign parity_err = r_parity_err;
  assign frame_err  = r_frame_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver: LSB-first and MSB-first instances share one stimulus stream.
module tb_serial_frame_receiver;
  import serial_frame_receiver_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_en;
  logic       serial_in;
  logic       ready;

  logic [3:0] l_out, m_out;
  logic       l_valid, l_perr, l_ferr, l_ovr, l_busy;
  logic       m_valid, m_perr, m_ferr, m_ovr, m_busy;
  logic [8:0] l_st, m_st;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  serial_frame_receiver #(.WIDTH(4), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bit_en(bit_en), .serial_in(serial_in),
    .Out(l_out), .valid(l_valid), .ready(ready), .parity_err(l_perr),
    .frame_err(l_ferr), .overrun(l_ovr), .busy(l_busy)
  );

  serial_frame_receiver #(.WIDTH(4), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .bit_en(bit_en), .serial_in(serial_in),
    .Out(m_out), .valid(m_valid), .ready(ready), .parity_err(m_perr),
    .frame_err(m_ferr), .overrun(m_ovr), .busy(m_busy)
  );

  // Status word: {valid, Out[3:0], parity_err, frame_err, overrun, busy}
  assign l_st = {l_valid, l_out, l_perr, l_ferr, l_ovr, l_busy};
  assign m_st = {m_valid, m_out, m_perr, m_ferr, m_ovr, m_busy};

  task automatic step(input logic b);
    serial_in = b;
    bit_en    = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [6:0] bits);
    for (int i = 6; i >= 0; i--) step(bits[i]);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    bit_en = 1'b0;
    serial_in = IDLE_LINE;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; bit_en = 1'b1; serial_in = START_BIT; ready = 1'b1;
    @(posedge clk);
    #1;
    n_vec++;
    if (l_st !== 9'b0_0000_0000) begin
      n_err++; $display("FAIL reset_lsb: got %b expected %b", l_st, 9'b0_0000_0000);
    end
    n_vec++;
    if (m_st !== 9'b0_0000_0000) begin
      n_err++; $display("FAIL reset_msb: got %b expected %b", m_st, 9'b0_0000_0000);
    end
    rst = 1'b0; bit_en = 1'b0; serial_in = IDLE_LINE; ready = 1'b0;
  endtask

  task automatic test_lsb_basic;
    do_reset();
    ready = 1'b1;
    step(START_BIT);
    n_vec++;
    if (l_st !== 9'b0_0000_0001) begin
      n_err++; $display("FAIL basic_busy: got %b expected %b", l_st, 9'b0_0000_0001);
    end
    step(1'b0); step(1'b1); step(1'b0); step(1'b1); step(1'b0);
    n_vec++;
    if (l_st !== 9'b0_0000_0001) begin
      n_err++; $display("FAIL basic_pre_stop: got %b expected %b", l_st, 9'b0_0000_0001);
    end
    step(STOP_BIT);
    n_vec++;
    if (l_st !== 9'b1_1010_0000) begin
      n_err++; $display("FAIL basic_word: got %b expected %b", l_st, 9'b1_1010_0000);
    end
    step(IDLE_LINE);
    n_vec++;
    if (l_st !== 9'b0_1010_0000) begin
      n_err++; $display("FAIL basic_valid_drop: got %b expected %b", l_st, 9'b0_1010_0000);
    end
  endtask

  task automatic test_msb_first;
    do_reset();
    ready = 1'b1;
    send_frame(7'b0_1010_0_1);
    n_vec++;
    if (m_st !== 9'b1_1010_0000) begin
      n_err++; $display("FAIL msb_word: got %b expected %b", m_st, 9'b1_1010_0000);
    end
    n_vec++;
    if (l_st !== 9'b1_0101_0000) begin
      n_err++; $display("FAIL msb_lsb_twin: got %b expected %b", l_st, 9'b1_0101_0000);
    end
    step(IDLE_LINE);
    send_frame(7'b0_1010_1_1);
    n_vec++;
    if (m_st !== 9'b1_1010_1000) begin
      n_err++; $display("FAIL msb_parity_err: got %b expected %b", m_st, 9'b1_1010_1000);
    end
    n_vec++;
    if (l_st !== 9'b1_0101_1000) begin
      n_err++; $display("FAIL lsb_parity_err: got %b expected %b", l_st, 9'b1_0101_1000);
    end
    step(IDLE_LINE);
  endtask

  task automatic test_back_to_back;
    do_reset();
    ready = 1'b0;
    send_frame(7'b0_0101_0_1);
    n_vec++;
    if (l_st !== 9'b1_1010_0000) begin
      n_err++; $display("FAIL b2b_first: got %b expected %b", l_st, 9'b1_1010_0000);
    end
    send_frame(7'b0_1010_0_1);
    n_vec++;
    if (l_st !== 9'b1_1010_0010) begin
      n_err++; $display("FAIL b2b_overrun: got %b expected %b", l_st, 9'b1_1010_0010);
    end
    ready = 1'b1;
    step(IDLE_LINE);
    ready = 1'b0;
    n_vec++;
    if (l_st !== 9'b0_1010_0010) begin
      n_err++; $display("FAIL b2b_consume: got %b expected %b", l_st, 9'b0_1010_0010);
    end
  endtask

  task automatic test_frame_error;
    do_reset();
    ready = 1'b1;
    send_frame(7'b0_0101_0_0);
    n_vec++;
    if (l_st !== 9'b0_0000_0100) begin
      n_err++; $display("FAIL ferr_flag: got %b expected %b", l_st, 9'b0_0000_0100);
    end
    step(IDLE_LINE);
    send_frame(7'b0_1100_0_1);
    n_vec++;
    if (l_st !== 9'b1_0011_0100) begin
      n_err++; $display("FAIL ferr_recover: got %b expected %b", l_st, 9'b1_0011_0100);
    end
    step(IDLE_LINE);
  endtask

  task automatic test_slow_strobe;
    logic [6:0] bits;
    bits = 7'b0_0101_0_1;
    do_reset();
    ready = 1'b1;
    for (int i = 6; i >= 1; i--) begin
      step(bits[i]);
      bit_en = 1'b0;
      serial_in = ~bits[i];
      repeat (2) @(posedge clk);
      #1;
      n_vec++;
      if (l_st !== 9'b0_0000_0001) begin
        n_err++; $display("FAIL slow_dwell_%0d: got %b expected %b", 6 - i, l_st, 9'b0_0000_0001);
      end
    end
    step(STOP_BIT);
    n_vec++;
    if (l_st !== 9'b1_1010_0000) begin
      n_err++; $display("FAIL slow_word: got %b expected %b", l_st, 9'b1_1010_0000);
    end
    bit_en = 1'b0;
    @(posedge clk);
    #1;
    n_vec++;
    if (l_st !== 9'b0_1010_0000) begin
      n_err++; $display("FAIL slow_valid_drop: got %b expected %b", l_st, 9'b0_1010_0000);
    end
  endtask

  task automatic test_reset_mid_frame;
    do_reset();
    ready = 1'b1;
    step(START_BIT); step(1'b1); step(1'b1);
    rst = 1'b1;
    step(START_BIT);
    rst = 1'b0;
    n_vec++;
    if (l_st !== 9'b0_0000_0000) begin
      n_err++; $display("FAIL midrst_lsb: got %b expected %b", l_st, 9'b0_0000_0000);
    end
    n_vec++;
    if (m_st !== 9'b0_0000_0000) begin
      n_err++; $display("FAIL midrst_msb: got %b expected %b", m_st, 9'b0_0000_0000);
    end
    send_frame(7'b0_1100_0_1);
    n_vec++;
    if (l_st !== 9'b1_0011_0000) begin
      n_err++; $display("FAIL midrst_next_lsb: got %b expected %b", l_st, 9'b1_0011_0000);
    end
    n_vec++;
    if (m_st !== 9'b1_1100_0000) begin
      n_err++; $display("FAIL midrst_next_msb: got %b expected %b", m_st, 9'b1_1100_0000);
    end
    step(IDLE_LINE);
  endtask

  initial begin
    rst = 1'b1;
    bit_en = 1'b0;
    serial_in = IDLE_LINE;
    ready = 1'b0;
    test_reset();
    test_lsb_basic();
    test_msb_first();
    test_back_to_back();
    test_frame_error();
    test_slow_strobe();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
